// File: rtl/credential_entry.sv
// credential_entry: turns keypad presses into the 4-digit username + 4-digit password frame.
// Optional idle timeout is compiled in by defining CREDENTIAL_ENTRY_TIMEOUT_EN.
module credential_entry #(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyValid,
    input  logic [4:0] keyCode,
    input  logic       resetCount,
    output logic [3:0] inputCount,
    output logic [4:0] userNameInput0,
    output logic [4:0] userNameInput1,
    output logic [4:0] userNameInput2,
    output logic [4:0] userNameInput3,
    output logic [4:0] passwordInput0,
    output logic [4:0] passwordInput1,
    output logic [4:0] passwordInput2,
    output logic [4:0] passwordInput3,
    output logic       entryDone
);
    localparam logic [4:0] L_DIGIT_MAX = 5'(DIGIT_MAX);
    logic       r_key_q;
    logic [3:0] r_count;
    logic [4:0] r_slot [8];
    logic       r_done;
    logic       w_press;
    logic       w_expire;
    logic       w_digit;
    logic [3:0] w_count_n;
    logic [3:0] w_dec;
    logic [4:0] w_slot_n [8];
    assign w_press = keyValid & ~r_key_q;
    assign w_digit = keyCode <= L_DIGIT_MAX;
    assign w_dec = r_count - 4'd1;
    // resetCount and timeout outrank the press, which is then dropped
    always_comb begin
        w_count_n = r_count;
        w_slot_n = r_slot;
        if (resetCount || w_expire || (w_press && keyCode == 5'd31)) begin
            w_count_n = 4'd0;
            for (int i = 0; i < 8; i++) w_slot_n[i] = 5'd0;
        end else if (w_press && w_digit && r_count != 4'd8) begin
            w_count_n = r_count + 4'd1;
            w_slot_n[r_count[2:0]] = keyCode;
        end else if (w_press && keyCode == 5'd30 && r_count != 4'd0) begin
            w_count_n = w_dec;
            w_slot_n[w_dec[2:0]] = 5'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q <= 1'b0;
            r_count <= 4'd0;
            r_done <= 1'b0;
            for (int i = 0; i < 8; i++) r_slot[i] <= 5'd0;
        end else begin
            r_key_q <= keyValid;
            r_count <= w_count_n;
            r_slot <= w_slot_n;
            r_done <= r_count == 4'd7 && w_count_n == 4'd8;
        end
    end
`ifdef CREDENTIAL_ENTRY_TIMEOUT_EN
    logic [26:0] r_timer;
    assign w_expire = r_timer == 27'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || resetCount || w_expire || w_press || r_count == 4'd0 || r_count == 4'd8)
            r_timer <= 27'd0;
        else
            r_timer <= r_timer + 27'd1;
    end
`else
    // never true for a legal TIMEOUT_CYCLES, so partial entries persist
    assign w_expire = TIMEOUT_CYCLES < 0;
`endif
    assign inputCount = r_count;
    assign userNameInput0 = r_slot[0];
    assign userNameInput1 = r_slot[1];
    assign userNameInput2 = r_slot[2];
    assign userNameInput3 = r_slot[3];
    assign passwordInput0 = r_slot[4];
    assign passwordInput1 = r_slot[5];
    assign passwordInput2 = r_slot[6];
    assign passwordInput3 = r_slot[7];
    assign entryDone = r_done;
endmodule

// File: tb/tb_credential_entry.sv
// tb_credential_entry: directed checks of credential_entry; build with CREDENTIAL_ENTRY_TIMEOUT_EN
// defined to exercise the 16-cycle idle timeout.
module tb_credential_entry;
    logic       clk = 1'b0;
    logic       rst;
    logic       keyValid;
    logic [4:0] keyCode;
    logic       resetCount;
    logic [3:0] inputCount;
    logic [4:0] u0, u1, u2, u3, p0, p1, p2, p3;
    logic       entryDone;
    logic [39:0] frame;
    int total = 0;
    int bad = 0;

    credential_entry #(.TIMEOUT_CYCLES(16), .DIGIT_MAX(9)) dut (
        .clk(clk), .rst(rst), .keyValid(keyValid), .keyCode(keyCode), .resetCount(resetCount),
        .inputCount(inputCount),
        .userNameInput0(u0), .userNameInput1(u1), .userNameInput2(u2), .userNameInput3(u3),
        .passwordInput0(p0), .passwordInput1(p1), .passwordInput2(p2), .passwordInput3(p3),
        .entryDone(entryDone)
    );

    always #5 clk = ~clk;
    assign frame = {u0, u1, u2, u3, p0, p1, p2, p3};

    function automatic logic [39:0] f8(input int a, b, c, d, e, f, g, h);
        return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(f), 5'(g), 5'(h)};
    endfunction

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int c);
        keyCode = 5'(c);
        keyValid = 1'b1;
        @(posedge clk);
        #1;
        keyValid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        gap(2);
        total++; if (inputCount !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", inputCount); end
        total++; if (frame !== 40'd0) begin bad++; $display("FAIL reset_frame got=%h exp=0", frame); end
        total++; if (entryDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", entryDone); end
        rst = 1'b0;
        gap(1);
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            press((i % 4) / 2);
            total++; if (inputCount !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, inputCount, i + 1); end
            total++; if (entryDone !== (i == 7)) begin bad++; $display("FAIL fill_done[%0d] got=%b exp=%b", i, entryDone, i == 7); end
            gap(1);
            total++; if (entryDone !== 1'b0) begin bad++; $display("FAIL fill_done_low[%0d] got=%b exp=0", i, entryDone); end
        end
        total++; if (frame !== f8(0, 0, 1, 1, 0, 0, 1, 1)) begin bad++; $display("FAIL fill_frame got=%h exp=%h", frame, f8(0, 0, 1, 1, 0, 0, 1, 1)); end
    endtask

    task automatic test_full;
        press(9);
        total++; if (inputCount !== 4'd8) begin bad++; $display("FAIL full_digit_count got=%0d exp=8", inputCount); end
        total++; if (entryDone !== 1'b0) begin bad++; $display("FAIL full_digit_done got=%b exp=0", entryDone); end
        total++; if (frame !== f8(0, 0, 1, 1, 0, 0, 1, 1)) begin bad++; $display("FAIL full_digit_frame got=%h", frame); end
        gap(1);
        press(30);
        total++; if (inputCount !== 4'd7) begin bad++; $display("FAIL full_bs_count got=%0d exp=7", inputCount); end
        total++; if (frame !== f8(0, 0, 1, 1, 0, 0, 1, 0)) begin bad++; $display("FAIL full_bs_frame got=%h", frame); end
        gap(1);
        press(5);
        total++; if (inputCount !== 4'd8) begin bad++; $display("FAIL refill_count got=%0d exp=8", inputCount); end
        total++; if (entryDone !== 1'b1) begin bad++; $display("FAIL refill_done got=%b exp=1", entryDone); end
        total++; if (p3 !== 5'd5) begin bad++; $display("FAIL refill_p3 got=%0d exp=5", p3); end
        gap(1);
        total++; if (entryDone !== 1'b0) begin bad++; $display("FAIL refill_done_low got=%b exp=0", entryDone); end
    endtask

    task automatic test_hold;
        press(31);
        gap(1);
        total++; if (inputCount !== 4'd0) begin bad++; $display("FAIL hold_pre_clear got=%0d exp=0", inputCount); end
        keyCode = 5'd2;
        keyValid = 1'b1;
        gap(10);
        keyValid = 1'b0;
        total++; if (inputCount !== 4'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", inputCount); end
        total++; if (frame !== f8(2, 0, 0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL hold_frame got=%h", frame); end
        gap(1);
        press(30); gap(1);
        total++; if (frame !== 40'd0 || inputCount !== 4'd0) begin bad++; $display("FAIL bs_to_zero got=%0d/%h exp=0/0", inputCount, frame); end
        press(30); gap(1);
        total++; if (inputCount !== 4'd0) begin bad++; $display("FAIL bs_at_zero got=%0d exp=0", inputCount); end
        press(20); gap(1);
        total++; if (inputCount !== 4'd0) begin bad++; $display("FAIL code20 got=%0d exp=0", inputCount); end
        press(10); gap(1);
        total++; if (inputCount !== 4'd0) begin bad++; $display("FAIL code10 got=%0d exp=0", inputCount); end
        press(9); gap(1);
        total++; if (inputCount !== 4'd1 || frame !== f8(9, 0, 0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL code9 got=%0d/%h exp=1/%h", inputCount, frame, f8(9, 0, 0, 0, 0, 0, 0, 0)); end
        press(31); gap(1);
    endtask

    task automatic test_reset_count;
        press(7); gap(1); press(8); gap(1); press(6); gap(1); press(4); gap(1);
        total++; if (inputCount !== 4'd4 || frame !== f8(7, 8, 6, 4, 0, 0, 0, 0)) begin bad++; $display("FAIL rc_pre got=%0d/%h exp=4/%h", inputCount, frame, f8(7, 8, 6, 4, 0, 0, 0, 0)); end
        resetCount = 1'b1;
        keyCode = 5'd3;
        keyValid = 1'b1;
        gap(1);
        resetCount = 1'b0;
        total++; if (inputCount !== 4'd0 || frame !== 40'd0) begin bad++; $display("FAIL rc_same_edge got=%0d/%h exp=0/0", inputCount, frame); end
        gap(1);
        total++; if (inputCount !== 4'd0) begin bad++; $display("FAIL rc_not_deferred got=%0d exp=0", inputCount); end
        keyValid = 1'b0;
        gap(1);
        resetCount = 1'b1;
        press(5); gap(1);
        resetCount = 1'b0;
        gap(1);
        total++; if (inputCount !== 4'd0 || frame !== 40'd0) begin bad++; $display("FAIL rc_held got=%0d/%h exp=0/0", inputCount, frame); end
    endtask

    task automatic test_clear_rst;
        for (int i = 1; i <= 6; i++) begin press(i); gap(1); end
        total++; if (inputCount !== 4'd6 || frame !== f8(1, 2, 3, 4, 5, 6, 0, 0)) begin bad++; $display("FAIL order got=%0d/%h exp=6/%h", inputCount, frame, f8(1, 2, 3, 4, 5, 6, 0, 0)); end
        press(31);
        total++; if (inputCount !== 4'd0 || frame !== 40'd0) begin bad++; $display("FAIL clear got=%0d/%h exp=0/0", inputCount, frame); end
        gap(1);
        press(1); gap(1); press(2); gap(1); press(3); gap(1);
        total++; if (inputCount !== 4'd3) begin bad++; $display("FAIL mid_pre got=%0d exp=3", inputCount); end
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        total++; if (inputCount !== 4'd0 || frame !== 40'd0 || entryDone !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%h/%b exp=0/0/0", inputCount, frame, entryDone); end
        rst = 1'b1;
        keyCode = 5'd4;
        keyValid = 1'b1;
        gap(1);
        rst = 1'b0;
        gap(1);
        total++; if (inputCount !== 4'd1 || frame !== f8(4, 0, 0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL rst_release_press got=%0d/%h exp=1/%h", inputCount, frame, f8(4, 0, 0, 0, 0, 0, 0, 0)); end
        keyValid = 1'b0;
        gap(1);
        press(31); gap(1);
    endtask

    task automatic test_timeout;
        press(1);
        gap(9);
        press(2);
        gap(15);
        total++; if (inputCount !== 4'd2) begin bad++; $display("FAIL idle15 got=%0d exp=2", inputCount); end
        gap(1);
`ifdef CREDENTIAL_ENTRY_TIMEOUT_EN
        total++; if (inputCount !== 4'd0 || frame !== 40'd0) begin bad++; $display("FAIL idle16 got=%0d/%h exp=0/0", inputCount, frame); end
`else
        total++; if (inputCount !== 4'd2 || frame !== f8(1, 2, 0, 0, 0, 0, 0, 0)) begin bad++; $display("FAIL idle16 got=%0d/%h exp=2/%h", inputCount, frame, f8(1, 2, 0, 0, 0, 0, 0, 0)); end
`endif
        press(31); gap(1);
        for (int i = 0; i < 8; i++) begin press(8 - i); gap(1); end
        gap(40);
        total++; if (inputCount !== 4'd8 || frame !== f8(8, 7, 6, 5, 4, 3, 2, 1)) begin bad++; $display("FAIL idle_full got=%0d/%h exp=8/%h", inputCount, frame, f8(8, 7, 6, 5, 4, 3, 2, 1)); end
    endtask

    initial begin
        rst = 1'b1;
        keyValid = 1'b0;
        keyCode = 5'd0;
        resetCount = 1'b0;
        test_reset;
        test_fill;
        test_full;
        test_hold;
        test_reset_count;
        test_clear_rst;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/credential_entry.md
# credential_entry

Upstream stage of the unlocker. Converts one-key-at-a-time keypad events into the eight-slot credential frame the unlocker consumes: four username digits, then four password digits, plus a running `inputCount`. Clears itself when the unlocker asserts `resetCount` after an attempt or command. Supports backspace, clear-all and an optional idle timeout.

## Interface
- `TIMEOUT_CYCLES`, default 100000000; idle cycles before a partial entry is discarded (used only when the timeout is compiled in).
- `DIGIT_MAX`, default 9; largest key code accepted as a digit.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `keyValid`  in  1  level from the debounced keypad scanner, synchronous to `clk`; one key press = one low-to-high transition.
- `keyCode`  in  5  key code, stable while `keyValid` is high; 0..`DIGIT_MAX` digit, 30 backspace, 31 clear, others ignored.
- `resetCount`  in  1  from the unlocker; clears the frame.
- `inputCount`  out  4  number of slots filled, 0..8.
- `userNameInput0..3`  out  5 each  username slots 0..3 (entry order).
- `passwordInput0..3`  out  5 each  password slots 0..3.
- `entryDone`  out  1  one-cycle pulse when the frame becomes complete.

## Operation
- Press detect: register `keyValid` into `keyValidQ`; press = `keyValid & ~keyValidQ`. `keyCode` is sampled only in the press cycle. Holding a key yields exactly one press.
- Slot order: count 0..3 → `userNameInput0..3`, count 4..7 → `passwordInput0..3`.
- Digit press (code ≤ `DIGIT_MAX`) with count < 8: write code into slot[count], count += 1. With count = 8: ignored, no change.
- Backspace (30) with count > 0: count −= 1, slot[count−1] cleared to 0. With count = 0: no-op.
- Clear (31): count = 0, all slots 0.
- Code in (`DIGIT_MAX`, 30): ignored.
- `entryDone` = 1 in the cycle following the edge at which count goes 7 → 8; 0 otherwise.
- `resetCount` high at an edge: count = 0, all slots 0, idle timer 0. `resetCount` beats a simultaneous press; the press is dropped, not deferred. While `resetCount` stays high, every press is dropped.
- Priority per edge: `rst` > `resetCount` > timeout expiry > key press.
- States (implicit in count): IDLE (0), USER (1..4), PASS (5..7), FULL (8). FULL leaves only via backspace, clear, `resetCount`, timeout (not applied in FULL) or `rst`.

## Timing
- Reset values: `inputCount` 0, all slots 0, `entryDone` 0, `keyValidQ` 0, idle timer 0.
- Latency: press at edge N → updated count/slot visible after edge N (one clock).
- `resetCount` at edge N → cleared outputs after edge N.
- A `keyValid` high at release from `rst` counts as a press on the first edge with `rst` low (`keyValidQ` was 0).
- `inputCount` never exceeds 8 and never wraps below 0.
- Slots are held constant between presses; the unlocker may sample them combinationally at any cycle.

## Configuration
- `CREDENTIAL_ENTRY_TIMEOUT_EN` defined: 27-bit idle timer counts cycles while 1 ≤ count ≤ 7 and no press; any press or clear resets it to 0. On reaching `TIMEOUT_CYCLES`−1, next edge clears count and slots exactly as `resetCount` does. The timer is held at 0 at count 0 or 8.
- Not defined: no timer logic synthesized; partial entries persist indefinitely.

## Test plan
- Reset then keys 0,0,1,1,0,0,1,1 (one press each, ≥2 cycles apart) → `inputCount` steps 1..8; username 0,0,1,1; password 0,0,1,1; `entryDone` single pulse after eighth press.
- Frame full, press 9 → no change, count 8; backspace → count 7, `passwordInput3` = 0; press 5 → `passwordInput3` = 5, second `entryDone` pulse.
- Hold `keyValid` high with code 2 for 10 cycles → count 1 only; backspace at count 0 → stays 0; code 20 → ignored.
- Count 4, `resetCount` and press of 3 on the same edge → count 0, all slots 0, press dropped.
- Clear (31) at count 6 → count 0, all slots 0; `rst` asserted mid-entry at count 3 → all outputs at reset values next cycle.
- With `CREDENTIAL_ENTRY_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16: two digits then idle → cleared exactly 16 cycles after last press; idle at count 8 → no clear; without the macro → count stays 2.
